stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Stopwatch controller that sequences a prescaler and a cascade of modulo digit counters (centiseconds ones/tens, seconds ones/tens) under user commands. The commands are start/stop, lap-freeze and clear. It sits between the debounced/one-shot button logic and the seven-segment display driver. It owns all run/pause/lap sequencing, so the counters only advance when the FSM allows it.

## Interface
Parameters:
- TICK_DIV, default 100000: clock cycles per centisecond tick, ≥ 2.
- PRE_WIDTH, default 17: prescaler width, must hold TICK_DIV-1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- start_stop  input  1  single-cycle command pulse: toggle run/pause.
- lap  input  1  single-cycle command pulse: freeze/release displayed time.
- clear  input  1  single-cycle command pulse: zero everything (honoured only when paused).
- running  output  1  high in RUN or LAP.
- lap_active  output  1  high in LAP.
- wrap  output  1  one-cycle pulse when time rolls 59.99 → 00.00.
- cs_ones, cs_tens, s_ones  output  4 each  displayed BCD digits, 0–9.
- s_tens  output  4  displayed BCD digit, 0–5.

## Operation
- FSM states: IDLE (zeroed, stopped), RUN, LAP (counting, display frozen), STOP (paused, value retained).
- Transitions, evaluated on the rising edge:
  - IDLE: start_stop → RUN. lap and clear are ignored.
  - RUN: start_stop → STOP. lap → LAP, capturing the live digits into the lap registers on the same edge. clear is ignored.
  - LAP: lap → RUN (display returns to live). start_stop → STOP (display returns to live). clear is ignored.
  - STOP: clear → IDLE. start_stop → RUN. lap is ignored.
- Priority for simultaneous pulses:
  - In STOP, clear beats start_stop.
  - In RUN/LAP, start_stop beats lap.
- Prescaler behaviour:
  - Counts 0..TICK_DIV-1 only in RUN/LAP, and wraps to 0.
  - tick = (state RUN or LAP) and prescaler == TICK_DIV-1.
  - Holds its value in STOP, so a pause does not lose the partial tick.
  - Zeroed on entry to IDLE.
- Digit cascade, advancing on tick:
  - cs_ones is mod 10.
  - cs_tens increments when cs_ones == 9.
  - s_ones increments when both cs digits == 9.
  - s_tens is mod 6 and increments when the three lower digits == 9.
  - All four digits carry in the same edge, with no ripple delay between digits.
- Rollover at 59.99: the next tick sets all digits to 0 and pulses wrap. Counting continues.
- Display outputs:
  - Show the lap registers in LAP, otherwise the live digits.
  - The live digits continue advancing while in LAP.
- Clear zeroes the live digits, the lap registers and the prescaler.
- Digit values never leave range. s_tens never exceeds 5.

## Timing
- Reset (async assert, sync release):
  - state = IDLE; prescaler, digits and lap registers = 0.
  - running = 0, lap_active = 0, wrap = 0, all digit outputs = 0.
- Command latency: a pulse sampled at edge k changes state, running and lap_active after edge k; the outputs are visible during cycle k+1.
- First increment: RUN entered at edge k from IDLE gives cs_ones = 1 after edge k+TICK_DIV.
- Digit outputs change only on the tick edge, or on the edge of a LAP entry/exit, or on clear.
- Pause/resume:
  - start_stop in the same cycle as tick: the tick increment is applied, then the state is STOP.
  - Resume continues from the held prescaler value.
- wrap is high for exactly one cycle, the cycle after the rollover edge. It is registered.
- Reset asserted mid-count: everything returns to the reset values immediately, with no clock needed.
- Command pulses longer than one cycle are treated as one pulse per high cycle. Upstream guarantees single-cycle pulses.

## Test plan
(TICK_DIV = 4 in simulation.)
- Reset, then start_stop pulse → running = 1 next cycle; cs_ones = 1 after 4 cycles; digits read 00.10 after 40 cycles.
- Run to 59.99, then one more tick → all digits 0, wrap high for exactly 1 cycle, running stays 1.
- RUN at 00.05, pulse lap → display frozen at 00.05 and lap_active = 1. After 20 cycles, pulse lap → display shows 00.10.
- Pause 2 cycles after a tick (prescaler = 2), wait 50 cycles, resume → next increment after 2 cycles, not 4. clear in RUN is ignored; clear in STOP → IDLE with all digits 0.
- In STOP, assert clear and start_stop together → IDLE, running = 0. In RUN, assert start_stop and lap together → STOP, lap_active = 0.
- Assert reset_n low mid-count between clock edges → all outputs 0 before the next rising edge.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/lap/clear sequencing for a centisecond
// prescaler and a four-digit BCD cascade (SS.CC, 00.00 .. 59.99).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | zeroed and stopped, waiting for start
// RUN   | counting, display shows the live digits
// LAP   | counting, display frozen on the captured lap digits
// STOP  | paused, live digits and partial prescaler count retained
module stopwatch_ctrl #(
    parameter int TICK_DIV  = 100000,
    parameter int PRE_WIDTH = 17
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic       running,
    output logic       lap_active,
    output logic       wrap,
    output logic [3:0] cs_ones,
    output logic [3:0] cs_tens,
    output logic [3:0] s_ones,
    output logic [3:0] s_tens
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAP  = 2'd2,
        STOP = 2'd3
    } state_t;

    localparam logic [PRE_WIDTH-1:0] PRE_MAX  = PRE_WIDTH'(TICK_DIV - 1);
    localparam logic [PRE_WIDTH-1:0] PRE_ZERO = '0;
    localparam logic [PRE_WIDTH-1:0] PRE_ONE  = PRE_WIDTH'(1);

    state_t               state;
    state_t               state_nxt;
    logic [PRE_WIDTH-1:0] pre;
    logic [3:0]           live_cs_ones, live_cs_tens, live_s_ones, live_s_tens;
    logic [3:0]           lap_cs_ones, lap_cs_tens, lap_s_ones, lap_s_tens;

    logic active;
    logic tick;
    logic do_clear;
    logic do_capture;
    logic at_max;

    // Qualifiers shared by the datapath registers.
    always_comb begin
        active     = (state == RUN) || (state == LAP);
        tick       = active && (pre == PRE_MAX);
        do_clear   = (state == STOP) && clear;
        do_capture = (state == RUN) && lap && !start_stop;
        at_max     = (live_s_tens == 4'd5) && (live_s_ones == 4'd9) &&
                     (live_cs_tens == 4'd9) && (live_cs_ones == 4'd9);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; start_stop outranks lap, clear outranks start_stop.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start_stop) state_nxt = RUN;
            RUN: begin
                if (start_stop) state_nxt = STOP;
                else if (lap)   state_nxt = LAP;
            end
            LAP: begin
                if (start_stop) state_nxt = STOP;
                else if (lap)   state_nxt = RUN;
            end
            STOP: begin
                if (clear)           state_nxt = IDLE;
                else if (start_stop) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: status flags and the live/lap display mux.
    always_comb begin
        running    = active;
        lap_active = (state == LAP);
        cs_ones    = live_cs_ones;
        cs_tens    = live_cs_tens;
        s_ones     = live_s_ones;
        s_tens     = live_s_tens;
        if (state == LAP) begin
            cs_ones = lap_cs_ones;
            cs_tens = lap_cs_tens;
            s_ones  = lap_s_ones;
            s_tens  = lap_s_tens;
        end
    end

    // Prescaler: counts only while active, holds in STOP so a pause keeps the partial tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      pre <= PRE_ZERO;
        else if (do_clear) pre <= PRE_ZERO;
        else if (active)   pre <= (pre == PRE_MAX) ? PRE_ZERO : pre + PRE_ONE;
    end

    // Digit cascade: all carries resolved combinationally so every digit moves on the same tick edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live_cs_ones <= 4'd0;
            live_cs_tens <= 4'd0;
            live_s_ones  <= 4'd0;
            live_s_tens  <= 4'd0;
        end else if (do_clear) begin
            live_cs_ones <= 4'd0;
            live_cs_tens <= 4'd0;
            live_s_ones  <= 4'd0;
            live_s_tens  <= 4'd0;
        end else if (tick) begin
            live_cs_ones <= (live_cs_ones == 4'd9) ? 4'd0 : live_cs_ones + 4'd1;
            if (live_cs_ones == 4'd9)
                live_cs_tens <= (live_cs_tens == 4'd9) ? 4'd0 : live_cs_tens + 4'd1;
            if ((live_cs_ones == 4'd9) && (live_cs_tens == 4'd9))
                live_s_ones <= (live_s_ones == 4'd9) ? 4'd0 : live_s_ones + 4'd1;
            if ((live_cs_ones == 4'd9) && (live_cs_tens == 4'd9) && (live_s_ones == 4'd9))
                live_s_tens <= (live_s_tens >= 4'd5) ? 4'd0 : live_s_tens + 4'd1;
        end
    end

    // Lap registers: snapshot of the pre-edge live digits when LAP is entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lap_cs_ones <= 4'd0;
            lap_cs_tens <= 4'd0;
            lap_s_ones  <= 4'd0;
            lap_s_tens  <= 4'd0;
        end else if (do_clear) begin
            lap_cs_ones <= 4'd0;
            lap_cs_tens <= 4'd0;
            lap_s_ones  <= 4'd0;
            lap_s_tens  <= 4'd0;
        end else if (do_capture) begin
            lap_cs_ones <= live_cs_ones;
            lap_cs_tens <= live_cs_tens;
            lap_s_ones  <= live_s_ones;
            lap_s_tens  <= live_s_tens;
        end
    end

    // Rollover flag, registered so it is high exactly in the cycle after the 59.99 -> 00.00 edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) wrap <= 1'b0;
        else          wrap <= tick && at_max;
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with a centisecond-count model and directed stimulus.
module tb_stopwatch_ctrl;

    localparam int TD = 4;

    logic       clk        = 1'b0;
    logic       reset_n    = 1'b0;
    logic       start_stop = 1'b0;
    logic       lap        = 1'b0;
    logic       clear      = 1'b0;
    logic       running, lap_active, wrap;
    logic [3:0] cs_ones, cs_tens, s_ones, s_tens;
    logic [15:0] disp;

    int n_checks = 0;
    int n_fail   = 0;

    // model: mode 0 idle, 1 run, 2 lap, 3 stop; time as a plain centisecond count
    int m_mode = 0;
    int m_pre  = 0;
    int m_cnt  = 0;
    int m_lap  = 0;
    bit m_wrap = 1'b0;

    stopwatch_ctrl #(.TICK_DIV(TD), .PRE_WIDTH(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .running    (running),
        .lap_active (lap_active),
        .wrap       (wrap),
        .cs_ones    (cs_ones),
        .cs_tens    (cs_tens),
        .s_ones     (s_ones),
        .s_tens     (s_tens)
    );

    assign disp = {s_tens, s_ones, cs_tens, cs_ones};

    always #5 clk = ~clk;

    function automatic logic [15:0] bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model, advanced on every rising edge or on reset assertion.
    initial begin : model
        int  nxt;
        bit  cnting;
        bit  tk;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_mode = 0; m_pre = 0; m_cnt = 0; m_lap = 0; m_wrap = 1'b0;
            end else begin
                cnting = (m_mode == 1) || (m_mode == 2);
                tk     = cnting && (m_pre == TD - 1);
                nxt    = m_mode;
                case (m_mode)
                    0: if (start_stop) nxt = 1;
                    1: if (start_stop) nxt = 3;
                       else if (lap) begin nxt = 2; m_lap = m_cnt; end
                    2: if (start_stop) nxt = 3;
                       else if (lap) nxt = 1;
                    default: if (clear) nxt = 0;
                             else if (start_stop) nxt = 1;
                endcase
                m_wrap = tk && (m_cnt == 5999);
                if (tk)     m_cnt = (m_cnt + 1) % 6000;
                if (cnting) m_pre = (m_pre + 1) % TD;
                if (m_mode == 3 && clear) begin m_cnt = 0; m_pre = 0; m_lap = 0; end
                m_mode = nxt;
            end
        end
    end

    // Every-cycle comparison against the model, on the falling edge.
    initial begin : compare
        forever begin
            @(negedge clk);
            chk("running", {15'd0, running}, {15'd0, (m_mode == 1 || m_mode == 2)});
            chk("lap_active", {15'd0, lap_active}, {15'd0, (m_mode == 2)});
            chk("wrap", {15'd0, wrap}, {15'd0, m_wrap});
            chk("display", disp, bcd(m_mode == 2 ? m_lap : m_cnt));
            chk("s_tens_range", {15'd0, (s_tens > 4'd5)}, 16'd0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit ss, input bit lp, input bit cl);
        start_stop = ss; lap = lp; clear = cl;
        @(posedge clk);
        #1;
        start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    endtask

    initial begin
        // reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_disp", disp, 16'h0000);
        chk("rst_run", {15'd0, running}, 16'd0);
        chk("rst_wrap", {15'd0, wrap}, 16'd0);
        reset_n = 1'b1;
        cyc(2);
        chk("idle_run", {15'd0, running}, 16'd0);

        // start and first increments
        pulse(1, 0, 0);
        chk("start_run", {15'd0, running}, 16'd1);
        cyc(3);
        chk("pre_first", disp, 16'h0000);
        cyc(1);
        chk("first_inc", disp, 16'h0001);
        cyc(36);
        chk("ten_cs", disp, 16'h0010);

        // run to 59.99 and roll over
        cyc(4 * 5989);
        chk("at_5999", disp, 16'h5999);
        cyc(3);
        chk("hold_5999", disp, 16'h5999);
        chk("no_wrap", {15'd0, wrap}, 16'd0);
        cyc(1);
        chk("rollover", disp, 16'h0000);
        chk("wrap_hi", {15'd0, wrap}, 16'd1);
        chk("run_after_wrap", {15'd0, running}, 16'd1);
        cyc(1);
        chk("wrap_lo", {15'd0, wrap}, 16'd0);

        // lap freeze at 00.05
        cyc(19);
        chk("pre_lap", disp, 16'h0005);
        pulse(0, 1, 0);
        chk("lap_disp", disp, 16'h0005);
        chk("lap_flag", {15'd0, lap_active}, 16'd1);
        cyc(9);
        chk("lap_frozen", disp, 16'h0005);
        cyc(10);
        chk("lap_frozen2", disp, 16'h0005);
        pulse(0, 1, 0);
        chk("lap_release", disp, 16'h0010);
        chk("lap_flag_off", {15'd0, lap_active}, 16'd0);

        // pause with partial prescaler, resume
        cyc(3);
        chk("pre_pause", disp, 16'h0011);
        cyc(1);
        pulse(1, 0, 0);
        chk("paused", {15'd0, running}, 16'd0);
        cyc(50);
        chk("pause_hold", disp, 16'h0011);
        pulse(1, 0, 0);
        chk("resumed", {15'd0, running}, 16'd1);
        cyc(1);
        chk("resume_1", disp, 16'h0011);
        cyc(1);
        chk("resume_2", disp, 16'h0012);

        // clear ignored in RUN, honoured in STOP
        pulse(0, 0, 1);
        chk("clr_run_ign", {15'd0, running}, 16'd1);
        chk("clr_run_disp", disp, 16'h0012);
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        chk("clr_stop_run", {15'd0, running}, 16'd0);
        chk("clr_stop_disp", disp, 16'h0000);

        // simultaneous commands
        pulse(1, 0, 0);
        cyc(10);
        pulse(1, 0, 0);
        chk("stop_at_2", disp, 16'h0002);
        pulse(1, 0, 1);
        chk("clr_beats_ss", {15'd0, running}, 16'd0);
        chk("clr_beats_disp", disp, 16'h0000);
        pulse(1, 0, 0);
        cyc(3);
        chk("pre_zeroed", disp, 16'h0000);
        cyc(1);
        chk("pre_zeroed2", disp, 16'h0001);
        pulse(1, 1, 0);
        chk("ss_beats_lap", {15'd0, running}, 16'd0);
        chk("ss_beats_lap_f", {15'd0, lap_active}, 16'd0);

        // asynchronous reset mid-count
        pulse(1, 0, 0);
        cyc(6);
        chk("before_arst", disp, 16'h0002);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_disp", disp, 16'h0000);
        chk("arst_run", {15'd0, running}, 16'd0);
        chk("arst_wrap", {15'd0, wrap}, 16'd0);
        cyc(1);
        chk("arst_hold", disp, 16'h0000);
        #2;
        reset_n = 1'b1;
        cyc(2);
        chk("post_arst", {15'd0, running}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
